// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared bus constants, owner codes and active-low level helpers
package bus_arbiter_pkg;
  localparam int BUS_MASTER_CH = 4;
  localparam int BUS_OWNER_W = 2;
  localparam logic ENABLE_ = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  typedef enum logic [BUS_OWNER_W-1:0] {
    BUS_OWNER_MASTER_0 = 2'd0,
    BUS_OWNER_MASTER_1 = 2'd1,
    BUS_OWNER_MASTER_2 = 2'd2,
    BUS_OWNER_MASTER_3 = 2'd3
  } bus_owner_e;
  function automatic logic [BUS_MASTER_CH-1:0] grant_n(input logic [BUS_OWNER_W-1:0] owner);
    for (int i = 0; i < BUS_MASTER_CH; i++)
      grant_n[i] = (owner == BUS_OWNER_W'(i)) ? ENABLE_ : DISABLE_;
  endfunction
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// bus_arb_rr_pick: first active-high request scanning circularly from start
module bus_arb_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [BUS_MASTER_CH-1:0] req,
  input  logic [BUS_OWNER_W-1:0]   start,
  output logic                     found,
  output logic [BUS_OWNER_W-1:0]   pick
);
  logic [BUS_MASTER_CH-1:0] rot;
  logic [BUS_OWNER_W-1:0] off;
  assign rot = BUS_MASTER_CH'({req, req} >> start);
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign found = |rot;
  assign pick = start + off;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin 4-master arbiter with parked, registered active-low grants and hold limit
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m0_req_,
  input  logic                   m1_req_,
  input  logic                   m2_req_,
  input  logic                   m3_req_,
  output logic                   m0_grnt_,
  output logic                   m1_grnt_,
  output logic                   m2_grnt_,
  output logic                   m3_grnt_,
  output logic [BUS_OWNER_W-1:0] bus_owner,
  output logic                   hold_expire
);
  logic [BUS_MASTER_CH-1:0] req, others;
  logic [BUS_OWNER_W-1:0] owner_q, owner_d, pick;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_max;
  logic own_req, found, at_lim, force_ho;
  assign req = {m3_req_ == ENABLE_, m2_req_ == ENABLE_, m1_req_ == ENABLE_, m0_req_ == ENABLE_};
  assign own_req = req[owner_q];
  assign others = req & ~(BUS_MASTER_CH'(1) << owner_q);
  bus_arb_rr_pick u_pick (
    .req   (others),
    .start (owner_q + 2'd1),
    .found (found),
    .pick  (pick)
  );
  // with no limit the counter just saturates at its full range
  assign hold_max = (MAX_HOLD != 0) ? HOLD_W'(MAX_HOLD - 1) : '1;
  assign at_lim = (MAX_HOLD != 0) && (hold_q == hold_max);
  assign force_ho = own_req && at_lim && found;
  assign hold_expire = force_ho && !reset;
  always_comb begin
    owner_d = ((!own_req || force_ho) && found) ? pick : owner_q;
    hold_d = (owner_d != owner_q || !own_req) ? '0 : (hold_q == hold_max) ? hold_q : hold_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= BUS_OWNER_MASTER_0;
      hold_q <= '0;
    end else begin
      owner_q <= owner_d;
      hold_q <= hold_d;
    end
  end
  assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grant_n(owner_q);
  assign bus_owner = owner_q;
endmodule
